// File: rtl/bch_wrapper_pkg.sv
`default_nettype none
//==============================================================================
// Package  : bch_wrapper_pkg
// Brief    : FSM state encoding and memory word-count helper shared by the
//            BCH encoder/decoder wrappers.
// Revision : 1.0 - initial release
//==============================================================================
package bch_wrapper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Must match the encoder-side write count, including its spare word.
    function automatic int word_count(input int ecc_bits, input int mem_width);
        return ecc_bits / mem_width + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bch_wrapper_rd_pipe.sv
`default_nettype none
//==============================================================================
// Module   : bch_wrapper_rd_pipe
// Brief    : C_RD_LATENCY-deep read-enable delay line marking valid read data.
// Revision : 1.0 - initial release
//==============================================================================
module bch_wrapper_rd_pipe
    import bch_wrapper_pkg::*;
#(
    parameter int C_RD_LATENCY = 1
) (
    input  logic I_clk,
    input  logic I_rst_n,
    input  logic I_clr,
    input  logic I_ren,
    output logic O_ren_dly
);

    logic [C_RD_LATENCY-1:0] r_pipe;

    generate
        if (C_RD_LATENCY == 1) begin : g_single
            always_ff @(posedge I_clk or negedge I_rst_n) begin
                if (!I_rst_n) begin
                    r_pipe <= '0;
                end else if (I_clr) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= I_ren;
                end
            end
        end else begin : g_multi
            always_ff @(posedge I_clk or negedge I_rst_n) begin
                if (!I_rst_n) begin
                    r_pipe <= '0;
                end else if (I_clr) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= {r_pipe[C_RD_LATENCY-2:0], I_ren};
                end
            end
        end
    endgenerate

    assign O_ren_dly = r_pipe[C_RD_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/bch_wrapper_ecc_loader.sv
`default_nettype none
//==============================================================================
// Module   : bch_wrapper_ecc_loader
// Brief    : Reads N words of helper memory and reassembles the BCH ECC vector.
//            Define BCH_WRAPPER_ECC_ZERO_CHECK_EN to add the erased-memory flag O_err.
// Revision : 1.0 - initial release
//==============================================================================
module bch_wrapper_ecc_loader
    import bch_wrapper_pkg::*;
#(
    parameter int C_ECC_BITS      = 40,
    parameter int C_I_MEMADDR     = 0,
    parameter int C_MEM_ADDR_SIZE = 10,
    parameter int C_MEM_DATA_SIZE = 8,
    parameter int C_RD_LATENCY    = 1
) (
    input  logic                       I_clk,
    input  logic                       I_rst_n,
    input  logic                       I_en,
    input  logic                       I_start,
    output logic [C_MEM_ADDR_SIZE-1:0] O_mem_raddr,
    output logic                       O_ren,
    input  logic [C_MEM_DATA_SIZE-1:0] I_mem_rdata,
    output logic [C_ECC_BITS-1:0]      O_ecc,
    output logic                       O_valid,
    output logic                       O_busy
`ifdef BCH_WRAPPER_ECC_ZERO_CHECK_EN
    ,
    output logic                       O_err
`endif
);

    localparam int                         C_N_WORDS = word_count(C_ECC_BITS, C_MEM_DATA_SIZE);
    localparam int                         C_CNT_W   = $clog2(C_N_WORDS + 1);
    localparam logic [C_CNT_W-1:0]         C_N_CNT   = C_CNT_W'(C_N_WORDS);
    localparam logic [C_MEM_ADDR_SIZE-1:0] C_BASE    = C_MEM_ADDR_SIZE'(C_I_MEMADDR);

    state_t                       r_state;
    logic                         r_start_d;
    logic [C_CNT_W-1:0]           r_iss_cnt;
    logic [C_CNT_W-1:0]           r_cap_cnt;
    logic [C_MEM_ADDR_SIZE-1:0]   r_raddr;
    logic                         r_ren;
    logic [C_ECC_BITS-1:0]        r_buf;
    logic [C_ECC_BITS-1:0]        r_ecc;
    logic                         r_valid;
    logic                         r_busy;
    logic [C_ECC_BITS-1:0]        w_buf_nxt;
    logic                         w_cap;
    logic                         w_start;
`ifdef BCH_WRAPPER_ECC_ZERO_CHECK_EN
    logic                         r_err;
`endif

    assign w_start = I_en & I_start & ~r_start_d;

    bch_wrapper_rd_pipe #(
        .C_RD_LATENCY (C_RD_LATENCY)
    ) u_rd_pipe (
        .I_clk     (I_clk),
        .I_rst_n   (I_rst_n),
        .I_clr     (~I_en),
        .I_ren     (r_ren),
        .O_ren_dly (w_cap)
    );

    // Word k lands on bits [k*W +: W]; bits of the last word beyond C_ECC_BITS are dropped.
    generate
        for (genvar b = 0; b < C_ECC_BITS; b++) begin : g_bit
            assign w_buf_nxt[b] = (r_cap_cnt == C_CNT_W'(b / C_MEM_DATA_SIZE))
                                ? I_mem_rdata[b % C_MEM_DATA_SIZE] : r_buf[b];
        end
    endgenerate

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state   <= ST_IDLE;
            r_start_d <= 1'b1;
            r_iss_cnt <= '0;
            r_cap_cnt <= '0;
            r_raddr   <= C_BASE;
            r_ren     <= 1'b0;
            r_buf     <= '0;
            r_ecc     <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
`ifdef BCH_WRAPPER_ECC_ZERO_CHECK_EN
            r_err     <= 1'b0;
`endif
        end else begin
            r_start_d <= I_start;
            r_valid   <= 1'b0;
            if (!I_en) begin
                r_state   <= ST_IDLE;
                r_iss_cnt <= '0;
                r_cap_cnt <= '0;
                r_raddr   <= C_BASE;
                r_ren     <= 1'b0;
                r_buf     <= '0;
                r_ecc     <= '0;
                r_busy    <= 1'b0;
`ifdef BCH_WRAPPER_ECC_ZERO_CHECK_EN
                r_err     <= 1'b0;
`endif
            end else begin
                if (w_cap && (r_cap_cnt != C_N_CNT)) begin
                    r_buf     <= w_buf_nxt;
                    r_cap_cnt <= r_cap_cnt + C_CNT_W'(1);
                end
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_state   <= ST_ISSUE;
                            r_ren     <= 1'b1;
                            r_raddr   <= C_BASE;
                            r_iss_cnt <= C_CNT_W'(1);
                            r_cap_cnt <= '0;
                            r_busy    <= 1'b1;
`ifdef BCH_WRAPPER_ECC_ZERO_CHECK_EN
                            r_err     <= 1'b0;
`endif
                        end
                    end
                    ST_ISSUE: begin
                        if (r_iss_cnt == C_N_CNT) begin
                            r_ren   <= 1'b0;
                            r_raddr <= C_BASE;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_raddr   <= r_raddr + C_MEM_ADDR_SIZE'(1);
                            r_iss_cnt <= r_iss_cnt + C_CNT_W'(1);
                        end
                    end
                    ST_DRAIN: begin
                        if (r_cap_cnt == C_N_CNT) begin
                            r_ecc   <= r_buf;
                            r_state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
`ifdef BCH_WRAPPER_ECC_ZERO_CHECK_EN
                        r_err   <= (r_ecc == '0);
`endif
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign O_mem_raddr = r_raddr;
    assign O_ren       = r_ren;
    assign O_ecc       = r_ecc;
    assign O_valid     = r_valid;
    assign O_busy      = r_busy;
`ifdef BCH_WRAPPER_ECC_ZERO_CHECK_EN
    assign O_err       = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bch_wrapper_ecc_loader.sv
`default_nettype none
//==============================================================================
// Module   : tb_bch_wrapper_ecc_loader
// Brief    : Directed bench for bch_wrapper_ecc_loader (latency 1 at base 0, latency 3
//            at wrapping base 1022); zero-check vectors under BCH_WRAPPER_ECC_ZERO_CHECK_EN.
// Revision : 1.0 - initial release
//==============================================================================
module tb_bch_wrapper_ecc_loader;

    localparam int AW     = 10;
    localparam int DW     = 8;
    localparam int EB     = 40;
    localparam int BASE_B = 1022;

    logic          clk = 1'b0;
    logic          rst_n, en, start;
    logic [AW-1:0] raddr_a, raddr_b;
    logic          ren_a, ren_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic [EB-1:0] ecc_a, ecc_b;
    logic          valid_a, valid_b, busy_a, busy_b;
`ifdef BCH_WRAPPER_ECC_ZERO_CHECK_EN
    logic          err_a, err_b;
`endif

    logic [7:0] dat [6];
    logic [7:0] pa;
    logic [7:0] pb [3];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    bch_wrapper_ecc_loader #(
        .C_ECC_BITS (EB), .C_I_MEMADDR (0), .C_MEM_ADDR_SIZE (AW),
        .C_MEM_DATA_SIZE (DW), .C_RD_LATENCY (1)
    ) u_dut_a (
        .I_clk (clk), .I_rst_n (rst_n), .I_en (en), .I_start (start),
        .O_mem_raddr (raddr_a), .O_ren (ren_a), .I_mem_rdata (rdata_a),
        .O_ecc (ecc_a), .O_valid (valid_a), .O_busy (busy_a)
`ifdef BCH_WRAPPER_ECC_ZERO_CHECK_EN
        , .O_err (err_a)
`endif
    );

    bch_wrapper_ecc_loader #(
        .C_ECC_BITS (EB), .C_I_MEMADDR (BASE_B), .C_MEM_ADDR_SIZE (AW),
        .C_MEM_DATA_SIZE (DW), .C_RD_LATENCY (3)
    ) u_dut_b (
        .I_clk (clk), .I_rst_n (rst_n), .I_en (en), .I_start (start),
        .O_mem_raddr (raddr_b), .O_ren (ren_b), .I_mem_rdata (rdata_b),
        .O_ecc (ecc_b), .O_valid (valid_b), .O_busy (busy_b)
`ifdef BCH_WRAPPER_ECC_ZERO_CHECK_EN
        , .O_err (err_b)
`endif
    );

    // Helper memory: six words from each instance's base, 0xEE elsewhere and when not read.
    function automatic logic [7:0] mem_word(input logic [AW-1:0] addr, input int base);
        int idx;
        idx = (int'(addr) - base + 1024) % 1024;
        if (idx < 6) return dat[idx];
        return 8'hEE;
    endfunction

    always @(posedge clk) begin
        pa    <= ren_a ? mem_word(raddr_a, 0) : 8'hEE;
        pb[0] <= ren_b ? mem_word(raddr_b, BASE_B) : 8'hEE;
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign rdata_a = pa;
    assign rdata_b = pb[2];

    function automatic logic [EB-1:0] exp_ecc();
        return {dat[4], dat[3], dat[2], dat[1], dat[0]};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_dat(input logic [7:0] d0, d1, d2, d3, d4, d5);
        dat[0] = d0; dat[1] = d1; dat[2] = d2; dat[3] = d3; dat[4] = d4; dat[5] = d5;
    endtask

    // mode 0: plain load, 1: extra start edge while busy, 2: I_en drop on 3rd read,
    // 3: reset in DRAIN with I_start held high afterwards.
    task automatic run_load(input int mode, input logic err_exp);
        int rc_a = 0, rc_b = 0, f_a = -1, l_a = -1, vc_a = 0, vc_b = 0;
        int vy_a = -1, vy_b = -1, late_ren = 0;
        logic [EB-1:0] ev_a = '0, ev_b = '0;
        logic er_a = 1'b0, er_b = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 20; c++) begin
            start = (mode == 1 && c == 1) || (mode == 3 && c >= 6);
            en    = !(mode == 2 && c == 2);
            if (mode == 3 && c == 6) rst_n = 1'b0;
            if (mode == 3 && c == 8) rst_n = 1'b1;
            @(negedge clk);
            if (ren_a) begin
                check_val("raddr_a", 64'(raddr_a), 64'(rc_a));
                if (f_a < 0) f_a = c;
                l_a = c;
                rc_a++;
                if (c >= 7) late_ren++;
            end
            if (ren_b) begin
                check_val("raddr_b", 64'(raddr_b), 64'((BASE_B + rc_b) % 1024));
                rc_b++;
                if (c >= 7) late_ren++;
            end
            if (valid_a) begin
                vc_a++; vy_a = c; ev_a = ecc_a;
`ifdef BCH_WRAPPER_ECC_ZERO_CHECK_EN
                er_a = err_a;
`endif
            end
            if (valid_b) begin
                vc_b++; vy_b = c; ev_b = ecc_b;
`ifdef BCH_WRAPPER_ECC_ZERO_CHECK_EN
                er_b = err_b;
`endif
            end
            if (mode == 2 && c == 3) begin
                check_val("abort_busy_a", 64'(busy_a), 64'd0);
                check_val("abort_ecc_a", 64'(ecc_a), 64'd0);
                check_val("abort_ren_a", 64'(ren_a), 64'd0);
                check_val("abort_busy_b", 64'(busy_b), 64'd0);
                check_val("abort_ecc_b", 64'(ecc_b), 64'd0);
            end
            if (mode == 3 && c == 6) begin
                check_val("rst_outs_a", {60'd0, ren_a, valid_a, busy_a, 1'b0}, 64'd0);
                check_val("rst_ecc_a", 64'(ecc_a), 64'd0);
                check_val("rst_raddr_b", 64'(raddr_b), 64'(BASE_B));
                check_val("rst_outs_b", {60'd0, ren_b, valid_b, busy_b, 1'b0}, 64'd0);
            end
            @(posedge clk); #1;
        end
        en = 1'b1;
        if (mode <= 1) begin
            check_val("ren_cnt_a", 64'(rc_a), 64'd6);
            check_val("ren_first_a", 64'(f_a), 64'd0);
            check_val("ren_last_a", 64'(l_a), 64'd5);
            check_val("ren_cnt_b", 64'(rc_b), 64'd6);
            check_val("valid_cnt_a", 64'(vc_a), 64'd1);
            check_val("valid_cnt_b", 64'(vc_b), 64'd1);
            check_val("valid_cyc_a", 64'(vy_a), 64'd9);
            check_val("valid_cyc_b", 64'(vy_b), 64'd11);
            check_val("ecc_a", 64'(ev_a), 64'(exp_ecc()));
            check_val("ecc_b", 64'(ev_b), 64'(exp_ecc()));
            check_val("ecc_hold_a", 64'(ecc_a), 64'(exp_ecc()));
            check_val("busy_end_a", 64'(busy_a), 64'd0);
`ifdef BCH_WRAPPER_ECC_ZERO_CHECK_EN
            check_val("err_a", 64'(er_a), 64'(err_exp));
            check_val("err_b", 64'(er_b), 64'(err_exp));
            check_val("err_hold_a", 64'(err_a), 64'(err_exp));
`endif
        end else begin
            check_val("abort_valid_a", 64'(vc_a), 64'd0);
            check_val("abort_valid_b", 64'(vc_b), 64'd0);
            check_val("abort_ren_cnt_a", 64'(rc_a), (mode == 2) ? 64'd3 : 64'd6);
            check_val("abort_late_ren", 64'(late_ren), 64'd0);
            check_val("abort_busy_end", {62'd0, busy_a, busy_b}, 64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        start = 1'b1;
        set_dat(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_outs_a", {61'd0, ren_a, valid_a, busy_a}, 64'd0);
        check_val("reset_ecc_a", 64'(ecc_a), 64'd0);
        check_val("reset_raddr_a", 64'(raddr_a), 64'd0);
        check_val("reset_raddr_b", 64'(raddr_b), 64'(BASE_B));
`ifdef BCH_WRAPPER_ECC_ZERO_CHECK_EN
        check_val("reset_err", {62'd0, err_a, err_b}, 64'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("start_held_no_load", {62'd0, busy_a, busy_b}, 64'd0);
        @(posedge clk); #1;

        run_load(0, 1'b0);
        check_val("ecc_const_a", 64'(ecc_a), 64'h55_4433_2211);

        set_dat(8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6);
        run_load(1, 1'b0);
        run_load(2, 1'b0);
        run_load(3, 1'b0);

        set_dat(8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A);
        run_load(0, 1'b0);

`ifdef BCH_WRAPPER_ECC_ZERO_CHECK_EN
        set_dat(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        run_load(0, 1'b1);
        set_dat(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        run_load(0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
